// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one dual-word read per instruction, holds the
// fetched {opcode, immediate} pair until the core retires it, then refetches.
module instr_fetch #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_ptr_i,
    input  logic        advance_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr0_o,
    output logic [15:0] mem_addr1_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [15:0] mem_rdata0_i,
    input  logic [15:0] mem_rdata1_i,
    output logic [31:0] instr_o,
    output logic [15:0] instr_ptr_o,
    output logic        instr_valid_o
);

    localparam logic [15:0] RESET_VECTOR_P1 = RESET_VECTOR + 16'd1;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_VALID
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        capture;
    logic        load_ptr;
    logic [15:0] ptr0;
    logic [15:0] ptr1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        load_ptr   = 1'b0;
        mem_req_o  = 1'b0;
        unique case (state)
            S_BOOT: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                mem_req_o = 1'b1;
                // rvalid only counts together with, or after, its grant
                if (mem_gnt_i) begin
                    if (mem_rvalid_i) begin
                        capture    = 1'b1;
                        state_next = S_VALID;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    capture    = 1'b1;
                    state_next = S_VALID;
                end
            end
            S_VALID: begin
                if (advance_i) begin
                    load_ptr   = 1'b1;
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr0        <= RESET_VECTOR;
            ptr1        <= RESET_VECTOR_P1;
            instr_o     <= '0;
            instr_ptr_o <= RESET_VECTOR;
        end else begin
            if (load_ptr) begin
                ptr0 <= next_ptr_i[31:16];
                ptr1 <= next_ptr_i[15:0];
            end
            if (capture) begin
                instr_o     <= {mem_rdata0_i, mem_rdata1_i};
                instr_ptr_o <= ptr0;
            end
        end
    end

    assign mem_addr0_o   = ptr0;
    assign mem_addr1_o   = ptr1;
    assign instr_valid_o = (state == S_VALID);

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch: a memory responder with random grant/rvalid
// latency, a queue of expected fetches and an independent output monitor.
module tb_instr_fetch;

    localparam logic [15:0] RV = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] next_ptr_i = '0;
    logic        advance_i = 1'b0;
    logic        mem_req_o;
    logic [15:0] mem_addr0_o;
    logic [15:0] mem_addr1_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [15:0] mem_rdata0_i = '0;
    logic [15:0] mem_rdata1_i = '0;
    logic [31:0] instr_o;
    logic [15:0] instr_ptr_o;
    logic        instr_valid_o;

    instr_fetch #(.RESET_VECTOR(RV)) dut (
        .clk          (clk),
        .rst          (rst),
        .next_ptr_i   (next_ptr_i),
        .advance_i    (advance_i),
        .mem_req_o    (mem_req_o),
        .mem_addr0_o  (mem_addr0_o),
        .mem_addr1_o  (mem_addr1_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata0_i (mem_rdata0_i),
        .mem_rdata1_i (mem_rdata1_i),
        .instr_o      (instr_o),
        .instr_ptr_o  (instr_ptr_o),
        .instr_valid_o(instr_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] ptr;
    } exp_t;

    logic [15:0] mem [65536];
    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;

    // responder / stimulus state
    bit          outstanding = 0;
    bit          req_seen = 0;
    bit          stale_next = 0;
    bit          expect_capture = 0;
    bit          spur_en = 0;
    int          g_wait = 0;
    int          rv_wait = 0;
    int          force_gw = 0;
    int          force_rw = 0;
    logic [15:0] exp_a0 = RV;
    logic [15:0] exp_a1 = RV + 16'd1;
    logic [15:0] ga0 = '0;
    logic [15:0] ga1 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int pick(input int forced, input int max_v);
        return (forced >= 0) ? forced : int'($urandom_range(max_v, 0));
    endfunction

    function automatic exp_t fetch_of(input logic [15:0] a0, input logic [15:0] a1);
        exp_t e;
        e.instr = {mem[a0], mem[a1]};
        e.ptr   = a0;
        return e;
    endfunction

    // One cycle of memory responder plus core stimulus, applied at a negedge.
    task automatic drive_cycle(input bit adv_rand, input bit adv_force, input logic [31:0] fptr);
        int r;
        mem_gnt_i      = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata0_i   = 16'($urandom);
        mem_rdata1_i   = 16'($urandom);
        advance_i      = 1'b0;
        next_ptr_i     = $urandom;
        expect_capture = 0;
        if (stale_next) begin
            mem_rvalid_i = 1'b1;
            stale_next   = 0;
        end else if (outstanding) begin
            check("req_low_in_wait", mem_req_o, 1'b0);
            if (rv_wait == 0) begin
                mem_rvalid_i   = 1'b1;
                mem_rdata0_i   = mem[ga0];
                mem_rdata1_i   = mem[ga1];
                outstanding    = 0;
                expect_capture = 1;
            end else begin
                rv_wait--;
            end
        end else if (mem_req_o) begin
            check("req_addr0", mem_addr0_o, exp_a0);
            check("req_addr1", mem_addr1_o, exp_a1);
            if (!req_seen) begin
                req_seen = 1;
                g_wait   = pick(force_gw, 3);
            end
            if (g_wait == 0) begin
                mem_gnt_i = 1'b1;
                req_seen  = 0;
                ga0       = mem_addr0_o;
                ga1       = mem_addr1_o;
                r         = pick(force_rw, 3);
                if (r == 0) begin
                    mem_rvalid_i   = 1'b1;
                    mem_rdata0_i   = mem[ga0];
                    mem_rdata1_i   = mem[ga1];
                    expect_capture = 1;
                end else begin
                    outstanding = 1;
                    rv_wait     = r - 1;
                end
            end else begin
                g_wait--;
                if (spur_en && $urandom_range(1, 0) == 1) mem_rvalid_i = 1'b1;
            end
        end else if (spur_en && $urandom_range(1, 0) == 1) begin
            mem_rvalid_i = 1'b1;
        end

        if (instr_valid_o) begin
            if (adv_force || (adv_rand && $urandom_range(3, 0) == 0)) begin
                advance_i  = 1'b1;
                next_ptr_i = adv_force ? fptr : $urandom;
                exp_a0     = next_ptr_i[31:16];
                exp_a1     = next_ptr_i[15:0];
                sb_q.push_back(fetch_of(exp_a0, exp_a1));
            end
        end else if (spur_en && $urandom_range(3, 0) == 0) begin
            advance_i = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n, input bit stale);
        rst            = 1'b1;
        outstanding    = 0;
        req_seen       = 0;
        expect_capture = 0;
        repeat (n) begin
            mem_gnt_i    = 1'($urandom);
            mem_rvalid_i = 1'($urandom);
            advance_i    = 1'($urandom);
            next_ptr_i   = $urandom;
            @(negedge clk);
        end
        rst = 1'b0;
        sb_q.delete();
        exp_a0 = RV;
        exp_a1 = RV + 16'd1;
        sb_q.push_back(fetch_of(exp_a0, exp_a1));
        stale_next = stale;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!instr_valid_o && n < budget) begin
            drive_cycle(0, 0, 32'h0);
            n++;
        end
        check("valid_within_budget", instr_valid_o, 1'b1);
    endtask

    // Monitor: samples just after each rising edge, pops the scoreboard on capture.
    initial begin
        bit          prev_valid;
        logic [31:0] prev_instr;
        logic [15:0] prev_ptr;
        exp_t        e;
        prev_valid = 0;
        prev_instr = '0;
        prev_ptr   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("rst_req", mem_req_o, 1'b0);
                check("rst_valid", instr_valid_o, 1'b0);
                check("rst_instr", instr_o, 32'h0);
                check("rst_iptr", instr_ptr_o, RV);
                check("rst_addr0", mem_addr0_o, RV);
                check("rst_addr1", mem_addr1_o, RV + 16'd1);
                prev_valid = 0;
            end else begin
                if (expect_capture) begin
                    check("capture_latency", instr_valid_o, 1'b1);
                    check("sb_depth", sb_q.size(), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("capture_instr", instr_o, e.instr);
                        check("capture_iptr", instr_ptr_o, e.ptr);
                    end
                end else if (!prev_valid) begin
                    check("no_unexpected_valid", instr_valid_o, 1'b0);
                end
                if (prev_valid && !advance_i) begin
                    check("valid_held", instr_valid_o, 1'b1);
                    check("instr_stable", instr_o, prev_instr);
                    check("iptr_stable", instr_ptr_o, prev_ptr);
                end
                if (prev_valid && advance_i) begin
                    check("adv_drop_valid", instr_valid_o, 1'b0);
                    check("adv_req", mem_req_o, 1'b1);
                    check("adv_addr0", mem_addr0_o, next_ptr_i[31:16]);
                    check("adv_addr1", mem_addr1_o, next_ptr_i[15:0]);
                end
                prev_valid = instr_valid_o;
            end
            prev_instr = instr_o;
            prev_ptr   = instr_ptr_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503) ^ 16'h5A5A;
        mem[16'h0000] = 16'h4123;
        mem[16'h0001] = 16'h0040;
        @(negedge clk);

        // boot with zero-wait memory
        force_gw = 0;
        force_rw = 0;
        do_reset(3, 0);
        wait_valid(20, n);
        check("boot_latency", n, 2);
        check("boot_instr", instr_o, 32'h41230040);
        check("boot_iptr", instr_ptr_o, 16'h0000);

        // grant after 3 cycles, rvalid 2 cycles after grant
        force_gw = 3;
        force_rw = 2;
        do_reset(2, 0);
        wait_valid(30, n);
        check("slow_latency", n, 7);
        check("slow_instr", instr_o, 32'h41230040);

        // advance to an explicit pointer pair
        force_gw = 0;
        force_rw = 0;
        drive_cycle(0, 1, 32'h00400041);
        wait_valid(20, n);
        check("adv_latency", n, 1);
        check("adv_iptr", instr_ptr_o, 16'h0040);
        check("adv_instr", instr_o, {mem[16'h0040], mem[16'h0041]});

        // wrapping pointer pair passes through unchanged
        drive_cycle(0, 1, 32'hFFFF0000);
        wait_valid(20, n);
        check("wrap_iptr", instr_ptr_o, 16'hFFFF);
        check("wrap_instr", instr_o, {mem[16'hFFFF], mem[16'h0000]});

        // spurious rvalid while VALID, spurious advance in REQ/WAIT
        spur_en  = 1;
        force_gw = -1;
        force_rw = -1;
        repeat (8) drive_cycle(0, 0, 32'h0);
        drive_cycle(0, 1, 32'h12345678);
        wait_valid(30, n);
        check("spur_iptr", instr_ptr_o, 16'h1234);

        // reset while waiting for rvalid, stale rvalid just after release
        spur_en  = 0;
        force_gw = 0;
        force_rw = 5;
        drive_cycle(0, 1, 32'h0BAD0BAE);
        drive_cycle(0, 0, 32'h0);
        drive_cycle(0, 0, 32'h0);
        force_rw = 0;
        do_reset(2, 1);
        wait_valid(20, n);
        check("restart_latency", n, 2);
        check("restart_iptr", instr_ptr_o, RV);
        check("restart_instr", instr_o, 32'h41230040);

        // randomised traffic with occasional resets
        spur_en  = 1;
        force_gw = -1;
        force_rw = -1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(199, 0) == 0) do_reset(int'($urandom_range(3, 1)), 1'($urandom));
            else drive_cycle(1, 0, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_VECTOR, default 16'h0000, address of the first instruction word fetched after reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 next_ptr_i  in  32  next-pointer stage output; [31:16] = next instruction word address (ptr0), [15:0] = following word address (ptr1).
REQ-005 advance_i  in  1  core retires the presented instruction this cycle; next_ptr_i is valid for it.
REQ-006 mem_req_o  out  1  dual-word read request.
REQ-007 mem_addr0_o  out  16  first word address.
REQ-008 mem_addr1_o  out  16  second word address.
REQ-009 mem_gnt_i  in  1  memory accepted request this cycle.
REQ-010 mem_rvalid_i  in  1  read data valid this cycle.
REQ-011 mem_rdata0_i  in  16  word at mem_addr0_o.
REQ-012 mem_rdata1_i  in  16  word at mem_addr1_o.
REQ-013 instr_o  out  32  {word0, word1}; [31:16] opcode word, [15:0] immediate word (used by core only if imm_valid).
REQ-014 instr_ptr_o  out  16  address of instr_o[31:16].
REQ-015 instr_valid_o  out  1  instr_o/instr_ptr_o hold a fetched instruction.

Function
REQ-016 Internal registers ptr0, ptr1 (16 bit each) hold the pending fetch addresses; mem_addr0_o = ptr0, mem_addr1_o = ptr1 at all times.
REQ-017 FSM states: BOOT, REQ, WAIT, VALID.
REQ-018 BOOT: mem_req_o=0, instr_valid_o=0; unconditional transition to REQ next cycle.
REQ-019 REQ: mem_req_o=1; ptr0/ptr1 held stable until mem_gnt_i=1.
REQ-020 REQ with mem_gnt_i=1 and mem_rvalid_i=0 -> WAIT; mem_req_o=0 from next cycle.
REQ-021 REQ with mem_gnt_i=1 and mem_rvalid_i=1 (zero-wait memory) -> capture data, go VALID directly.
REQ-022 mem_rvalid_i without a prior or concurrent grant (BOOT, REQ without gnt, VALID) is ignored.
REQ-023 WAIT: mem_req_o=0; on mem_rvalid_i=1 -> capture, go VALID; otherwise stay indefinitely.
REQ-024 Capture: instr_o <= {mem_rdata0_i, mem_rdata1_i}, instr_ptr_o <= ptr0, instr_valid_o <= 1.
REQ-025 VALID: instr_o/instr_ptr_o/instr_valid_o held stable while advance_i=0.
REQ-026 VALID with advance_i=1: ptr0 <= next_ptr_i[31:16], ptr1 <= next_ptr_i[15:0], instr_valid_o <= 0, -> REQ.
REQ-027 advance_i is ignored in every state except VALID.
REQ-028 Addresses taken verbatim; 16'hFFFF / 16'h0000 wrap pairs from upstream are passed through unchanged.
REQ-029 Latency: reset release to instr_valid_o=1 is 2 cycles with zero-wait memory; advance_i to next instr_valid_o=1 is 2 cycles with zero-wait memory, +1 per grant-wait or rvalid-wait cycle.
REQ-030 At most one outstanding request; no new request until the previous response is captured.

Reset
REQ-031 While rst=1: state=BOOT, ptr0=RESET_VECTOR, ptr1=RESET_VECTOR+1 (mod 2^16), mem_req_o=0, instr_valid_o=0, instr_o=0, instr_ptr_o=RESET_VECTOR.
REQ-032 rst=1 mid-transaction (REQ or WAIT) aborts it; a late mem_rvalid_i after reset is ignored (REQ-022).
REQ-033 rst takes priority over advance_i, mem_gnt_i and mem_rvalid_i in the same cycle.

Verification
REQ-034 Boot, zero-wait memory (gnt=rvalid=1 same cycle), mem[0]=16'h4123, mem[1]=16'h0040 -> cycle 2 after rst release: instr_valid_o=1, instr_o=32'h41230040, instr_ptr_o=16'h0000.
REQ-035 Grant delayed 3 cycles, rvalid 2 cycles after gnt -> mem_addr0_o/1_o stable 16'h0000/16'h0001 through grant, mem_req_o=0 in WAIT, valid asserted cycle after rvalid.
REQ-036 VALID, advance_i=1 with next_ptr_i=32'h00400041 -> next request addr0=16'h0040, addr1=16'h0041; instr_ptr_o=16'h0040 on capture.
REQ-037 Wrap: next_ptr_i=32'hFFFF0000 -> mem_addr0_o=16'hFFFF, mem_addr1_o=16'h0000, instr_o={mem[FFFF],mem[0000]}.
REQ-038 Spurious mem_rvalid_i in VALID and advance_i pulses in REQ/WAIT -> outputs unchanged, no state change.
REQ-039 rst asserted in WAIT, stale rvalid one cycle after release -> ignored; fetch restarts at RESET_VECTOR.
